// File: rtl/sram_ctrl.sv
// sram_ctrl
//   Data-memory back end behind the MEM stage. It turns each 32-bit load or
//   store into two 16-bit accesses on an asynchronous SRAM: the low half
//   first, then the high half. While an access is in flight, ready is low.
//   The top level uses ~ready to freeze the pipeline registers and the PC.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   MEM_R_EN     load request from the MEM stage
//   MEM_W_EN     store request from the MEM stage (wins if both are high)
//   address      byte address (ALU result); bits [1:0] are ignored
//   ST_val       store data
//   read_data    load result; holds until the next load overwrites it
//   ready        1 = MEM stage may advance, 0 = freeze the pipeline
//   sram_addr    SRAM halfword address
//   sram_dq_out  write data to the SRAM
//   sram_dq_oe   1 = controller drives the DQ bus
//   sram_dq_in   read data from the SRAM
//   sram_we_n    active-low write strobe
//   sram_oe_n    active-low output enable
module sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        ST_val,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  localparam int unsigned   CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               wr_q;
  logic [SRAM_AW-2:0] word_q;
  logic [15:0]        st_hi_q;
  logic [31:0]        rd_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [15:0]        dq_q;
  logic               dq_oe_q;
  logic               we_n_q;
  logic               oe_n_q;

  logic               req;
  logic               last;
  logic [31:0]        off;
  logic [SRAM_AW-2:0] word_d;
  logic               unused_addr_bits;

  assign req  = MEM_R_EN | MEM_W_EN;
  assign last = (cnt_q == CNT_LAST);

  // Word index relative to BASE_ADDR. The wrap mod 2^(SRAM_AW-1) falls out
  // of taking only the low bits of the offset.
  assign off              = address - 32'(BASE_ADDR);
  assign word_d           = off[SRAM_AW:2];
  assign unused_addr_bits = ^{off[31:SRAM_AW+1], off[1:0]};

  // Single FSM block. SRAM-side outputs are loaded on the edge that enters a
  // state, so they line up with that state's cycle without a combinational
  // decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      word_q  <= '0;
      st_hi_q <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      dq_oe_q <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= LO;
            cnt_q   <= '0;
            wr_q    <= MEM_W_EN;
            word_q  <= word_d;
            st_hi_q <= ST_val[31:16];
            addr_q  <= {word_d, 1'b0};
            if (MEM_W_EN) dq_q <= ST_val[15:0];
            dq_oe_q <= MEM_W_EN;
            we_n_q  <= ~MEM_W_EN;
            oe_n_q  <= MEM_W_EN;
          end
        end
        LO: begin
          if (last) begin
            // The SRAM has had the whole LO window to settle; capture now.
            if (!wr_q) rd_q[15:0] <= sram_dq_in;
            state_q <= HI;
            cnt_q   <= '0;
            addr_q  <= {word_q, 1'b1};
            if (wr_q) dq_q <= st_hi_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HI: begin
          if (last) begin
            if (!wr_q) rd_q[31:16] <= sram_dq_in;
            state_q <= DONE;
            cnt_q   <= '0;
            dq_oe_q <= 1'b0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;   // request inputs ignored here
        default: state_q <= IDLE;
      endcase
    end
  end

  // ready is combinational so the request cycle itself stalls the pipeline.
  assign ready       = (state_q == DONE) | ((state_q == IDLE) & ~req);
  assign read_data   = rd_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl. A halfword SRAM array reacts to the controller's strobes.
// Separately, a transaction model tracks the phase of each access by
// counting cycles. It also keeps its own memory image that is updated one
// half at a time, and from these it computes every expected output.
module tb_sram_ctrl;
  localparam int W    = 2;
  localparam int BASE = 1024;
  localparam int AW   = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEM_R_EN, MEM_W_EN;
  logic [31:0]   address, ST_val;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;
  logic          sram_we_n, sram_oe_n;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  sram_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .ST_val(ST_val), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  // Physical SRAM driven only by the strobes
  bit [15:0] sram [0:(1<<AW)-1];
  always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq_out;
  assign sram_dq_in = sram_oe_n ? 16'h0000 : sram[sram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model. m_k is the cycle index within an access:
  // 0 = idle, 1..2W = SRAM halves, 2W+1 = done.
  int          m_k;
  bit          m_wr;
  logic [16:0] m_word;
  logic [31:0] m_val, m_rd;
  bit   [15:0] mmem [0:(1<<AW)-1];
  logic [31:0] m_off;
  assign m_off = address - 32'(BASE);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_k  <= 0;
      m_rd <= '0;
    end else if (m_k == 0) begin
      if (MEM_W_EN || MEM_R_EN) begin
        m_k    <= 1;
        m_wr   <= MEM_W_EN;
        m_word <= m_off[18:2];
        m_val  <= ST_val;
      end
    end else begin
      if (m_k == W) begin
        if (m_wr) mmem[{m_word, 1'b0}] <= m_val[15:0];
        else      m_rd[15:0] <= mmem[{m_word, 1'b0}];
      end
      if (m_k == 2*W) begin
        if (m_wr) mmem[{m_word, 1'b1}] <= m_val[31:16];
        else      m_rd[31:16] <= mmem[{m_word, 1'b1}];
      end
      m_k <= (m_k == 2*W+1) ? 0 : m_k + 1;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      if (m_k == 0) begin
        chk("ready_idle", {31'd0, ready}, {31'd0, !(MEM_R_EN || MEM_W_EN)});
        chk("strobes_idle", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b110);
        chk("rd_idle", read_data, m_rd);
      end else if (m_k == 2*W+1) begin
        chk("ready_done", {31'd0, ready}, 32'd1);
        chk("strobes_done", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b110);
        chk("rd_done", read_data, m_rd);
      end else begin
        chk("ready_busy", {31'd0, ready}, 32'd0);
        chk("addr_busy", 32'(sram_addr), 32'({m_word, m_k > W}));
        if (m_wr) begin
          chk("strobes_wr", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b011);
          chk("dq_wr", 32'(sram_dq_out), 32'((m_k > W) ? m_val[31:16] : m_val[15:0]));
        end else begin
          chk("strobes_rd", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b100);
        end
      end
    end
  end

  // Per-access snapshots used by the literal checks
  logic [AW-1:0] cap_addr [0:19];
  logic [15:0]   cap_dq   [0:19];
  logic          cap_we   [0:19];
  logic          cap_oe   [0:19];
  logic [31:0]   cap_rd;

  // Caller starts at posedge+1. Holds the request until ready, then drops it
  // one posedge later.
  task automatic access(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] v, output int stall);
    bit got = 1'b0;
    MEM_R_EN = r; MEM_W_EN = w; address = a; ST_val = v;
    stall = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      cap_addr[i] = sram_addr; cap_dq[i] = sram_dq_out;
      cap_we[i] = sram_we_n; cap_oe[i] = sram_oe_n;
      if (ready) begin got = 1'b1; cap_rd = read_data; end
      else stall++;
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    MEM_R_EN = 0; MEM_W_EN = 0;
  endtask

  int st;

  initial begin
    rst = 1'b0; MEM_R_EN = 0; MEM_W_EN = 0; address = '0; ST_val = '0;
    cmp_en = 1'b1;

    // 1 reset
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_rd", read_data, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 2 store 1028 <- DEADBEEF
    access(0, 1, 32'd1028, 32'hDEADBEEF, st);
    chk("t2_stall", st, 2*W+1);
    chk("t2_addr_c1", 32'(cap_addr[1]), 32'd2);
    chk("t2_dq_c1", 32'(cap_dq[1]), 32'h0000BEEF);
    chk("t2_we_c2", {31'd0, cap_we[2]}, 32'd0);
    chk("t2_addr_c3", 32'(cap_addr[3]), 32'd3);
    chk("t2_dq_c4", 32'(cap_dq[4]), 32'h0000DEAD);
    repeat (2) @(posedge clk); #1;

    // 3 load 1028, then hold through idle cycles
    access(1, 0, 32'd1028, 32'h0, st);
    chk("t3_rd_done", cap_rd, 32'hDEADBEEF);
    chk("t3_oe_c1", {31'd0, cap_oe[1]}, 32'd0);
    chk("t3_oe_c4", {31'd0, cap_oe[4]}, 32'd0);
    repeat (10) @(negedge clk);
    chk("t3_rd_hold", read_data, 32'hDEADBEEF);
    @(posedge clk); #1;

    // 4 back-to-back load then store, then read back the store
    access(1, 0, 32'd1028, 32'h0, st);
    chk("t4_stall_ld", st, 2*W+1);
    access(0, 1, 32'd1032, 32'hCAFEF00D, st);
    chk("t4_stall_st", st, 2*W+1);
    access(1, 0, 32'd1032, 32'h0, st);
    chk("t4_readback", cap_rd, 32'hCAFEF00D);
    @(posedge clk); #1;

    // 5 both enables -> write wins
    access(1, 1, 32'd1024, 32'h12345678, st);
    chk("t5_we_c1", {31'd0, cap_we[1]}, 32'd0);
    chk("t5_addr_c1", 32'(cap_addr[1]), 32'd0);
    chk("t5_rd_kept", cap_rd, 32'hCAFEF00D);
    access(1, 0, 32'd1024, 32'h0, st);
    chk("t5_readback", cap_rd, 32'h12345678);
    @(posedge clk); #1;

    // 6 reset during HI of a store
    MEM_W_EN = 1; address = 32'd1100; ST_val = 32'hA5A55A5A;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0; MEM_W_EN = 0;
    #1;
    chk("t6_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("t6_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("t6_ready", {31'd0, ready}, 32'd1);
    repeat (2) @(posedge clk); #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_ready_after", {31'd0, ready}, 32'd1);
    chk("t6_we_after", {31'd0, sram_we_n}, 32'd1);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
